// File: rtl/fact_pkg.sv
// Shared constants for the factorization quiz: display state codes and question-ROM widths.
package fact_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned Q_W       = 7;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned ROM_DEPTH = 8;

  // Display state codes, also decoded by the 7-segment stage
  localparam logic [STATE_W-1:0] IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] QUESTION = 4'd1;
  localparam logic [STATE_W-1:0] INPUT    = 4'd2;
  localparam logic [STATE_W-1:0] JUDGE    = 4'd3;
  localparam logic [STATE_W-1:0] RESULT   = 4'd4;
  localparam logic [STATE_W-1:0] FINISH   = 4'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = IDLE,
    S_QUESTION = QUESTION,
    S_INPUT    = INPUT,
    S_JUDGE    = JUDGE,
    S_RESULT   = RESULT,
    S_FINISH   = FINISH
  } state_e;

  // One question: binary value plus its decimal digits
  typedef struct packed {
    logic [Q_W-1:0]     q;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } qentry_t;

endpackage

// File: rtl/fact_qrom.sv
// Question ROM: value and pre-split decimal digits, so no divider is needed downstream.
module fact_qrom
  import fact_pkg::*;
#(
  parameter int unsigned Q_OVR = 0  // nonzero forces every entry to this value
) (
  input  logic [IDX_W-1:0]   index,
  output logic [Q_W-1:0]     q,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);

  localparam logic [Q_W-1:0]     OVR_Q = Q_W'(Q_OVR);
  localparam logic [DIGIT_W-1:0] OVR_T = DIGIT_W'(Q_OVR / 10);
  localparam logic [DIGIT_W-1:0] OVR_O = DIGIT_W'(Q_OVR % 10);

  qentry_t entry_c;

  // Table lookup; indices 8..15 alias 0..7
  always_comb begin
    entry_c = '{q: 7'd12, tens: 4'd1, ones: 4'd2};
    case (index)
      4'd0, 4'd8:  entry_c = '{q: 7'd12, tens: 4'd1, ones: 4'd2};
      4'd1, 4'd9:  entry_c = '{q: 7'd15, tens: 4'd1, ones: 4'd5};
      4'd2, 4'd10: entry_c = '{q: 7'd21, tens: 4'd2, ones: 4'd1};
      4'd3, 4'd11: entry_c = '{q: 7'd35, tens: 4'd3, ones: 4'd5};
      4'd4, 4'd12: entry_c = '{q: 7'd49, tens: 4'd4, ones: 4'd9};
      4'd5, 4'd13: entry_c = '{q: 7'd27, tens: 4'd2, ones: 4'd7};
      4'd6, 4'd14: entry_c = '{q: 7'd77, tens: 4'd7, ones: 4'd7};
      default:     entry_c = '{q: 7'd91, tens: 4'd9, ones: 4'd1};
    endcase
    if (Q_OVR != 0) entry_c = '{q: OVR_Q, tens: OVR_T, ones: OVR_O};
  end

  assign q    = entry_c.q;
  assign tens = entry_c.tens;
  assign ones = entry_c.ones;

endmodule

// File: rtl/fact_game_ctrl.sv
// Quiz sequencer: question display, timed input, iterative divisibility judge, result and score.
module fact_game_ctrl
  import fact_pkg::*;
#(
  parameter int unsigned NQ       = 8,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned LIMIT    = 9,
  parameter int unsigned QSHOW    = 2,
  parameter int unsigned Q_OVR    = 0
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       START,
  input  logic       ENTER,
  input  logic [3:0] SW,
  output logic [3:0] STATE,
  output logic [3:0] QUE_T,
  output logic [3:0] QUE_O,
  output logic [3:0] DIN,
  output logic [3:0] SCORE,
  output logic [3:0] TIME_LEFT,
  output logic       LED_OK,
  output logic       LED_NG
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned QCNT_W = (QSHOW > 1) ? $clog2(QSHOW) : 1;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q;
  logic [QCNT_W-1:0]    qcnt_q, qcnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [Q_W-1:0]       q_q, q_d;
  logic [Q_W-1:0]       rem_q, rem_d;
  logic [DIGIT_W-1:0]   que_t_q, que_t_d, que_o_q, que_o_d;
  logic [DIGIT_W-1:0]   din_q, din_d, score_q, score_d, time_q, time_d;
  logic                 ok_q, ok_d, ng_q, ng_d;

  logic                 tick_c;
  logic [IDX_W-1:0]     rom_idx_c;
  logic [Q_W-1:0]       rom_q_c;
  logic [DIGIT_W-1:0]   rom_t_c, rom_o_c;
  logic [Q_W-1:0]       din_ext_c;
  logic                 din_bad_c;

  assign tick_c    = (div_q == DIV_W'(TICK_DIV - 1));
  // Only RESULT advances to a later question; every other load is question 0
  assign rom_idx_c = (state_q == S_RESULT) ? idx_q + IDX_W'(1) : '0;
  assign din_ext_c = Q_W'(din_q);
  assign din_bad_c = (din_q < 4'd2) || (din_q > 4'd9) || (din_ext_c >= q_q);

  fact_qrom #(.Q_OVR(Q_OVR)) u_qrom (
    .index (rom_idx_c),
    .q     (rom_q_c),
    .tens  (rom_t_c),
    .ones  (rom_o_c)
  );

  // Free-running 1 s tick divider, never realigned by game events
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      idx_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      que_t_q <= '0;
      que_o_q <= '0;
      din_q   <= '0;
      score_q <= '0;
      time_q  <= DIGIT_W'(LIMIT);
      ok_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      que_t_q <= que_t_d;
      que_o_q <= que_o_d;
      din_q   <= din_d;
      score_q <= score_d;
      time_q  <= time_d;
      ok_q    <= ok_d;
      ng_q    <= ng_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    idx_d   = idx_q;
    q_d     = q_q;
    rem_d   = rem_q;
    que_t_d = que_t_q;
    que_o_d = que_o_q;
    din_d   = din_q;
    score_d = score_q;
    time_d  = time_q;
    ok_d    = ok_q;
    ng_d    = ng_q;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (START) begin
          idx_d   = '0;
          score_d = '0;
          q_d     = rom_q_c;
          que_t_d = rom_t_c;
          que_o_d = rom_o_c;
          qcnt_d  = '0;
          ok_d    = 1'b0;
          ng_d    = 1'b0;
          state_d = S_QUESTION;
        end
      end

      S_QUESTION: begin
        if (tick_c) begin
          if (qcnt_q == QCNT_W'(QSHOW - 1)) begin
            time_d  = DIGIT_W'(LIMIT);
            state_d = S_INPUT;
          end else begin
            qcnt_d = qcnt_q + QCNT_W'(1);
          end
        end
      end

      S_INPUT: begin
        if (tick_c && time_q != '0) time_d = time_q - DIGIT_W'(1);
        // An answer on the expiring tick still wins over the timeout
        if (ENTER) begin
          din_d   = SW;
          rem_d   = q_q;
          state_d = S_JUDGE;
        end else if (tick_c && time_q <= DIGIT_W'(1)) begin
          ng_d    = 1'b1;
          state_d = S_RESULT;
        end
      end

      S_JUDGE: begin
        if (din_bad_c) begin
          ng_d    = 1'b1;
          state_d = S_RESULT;
        end else if (rem_q >= din_ext_c) begin
          rem_d = rem_q - din_ext_c;
        end else begin
          if (rem_q == '0) begin
            ok_d = 1'b1;
            if (score_q != 4'hF) score_d = score_q + DIGIT_W'(1);
          end else begin
            ng_d = 1'b1;
          end
          state_d = S_RESULT;
        end
      end

      S_RESULT: begin
        if (tick_c) begin
          ok_d = 1'b0;
          ng_d = 1'b0;
          if (idx_q == IDX_W'(NQ - 1)) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            q_d     = rom_q_c;
            que_t_d = rom_t_c;
            que_o_d = rom_o_c;
            qcnt_d  = '0;
            state_d = S_QUESTION;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign STATE     = state_q;
  assign QUE_T     = que_t_q;
  assign QUE_O     = que_o_q;
  assign DIN       = din_q;
  assign SCORE     = score_q;
  assign TIME_LEFT = time_q;
  assign LED_OK    = ok_q;
  assign LED_NG    = ng_q;

endmodule

// File: tb/tb_fact_game_ctrl.sv
// Directed bench for fact_game_ctrl: full rounds, timeouts, restart, async reset and a worst-case judge.
module tb_fact_game_ctrl;
  import fact_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       START = 1'b0, ENTER = 1'b0;
  logic [3:0] SW = 4'd0;
  logic [3:0] STATE, QUE_T, QUE_O, DIN, SCORE, TIME_LEFT;
  logic       LED_OK, LED_NG;

  logic       b_start = 1'b0, b_enter = 1'b0;
  logic [3:0] b_sw = 4'd0;
  logic [3:0] b_state, b_que_t, b_que_o, b_din, b_score, b_time;
  logic       b_ok, b_ng;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fact_game_ctrl #(.NQ(8), .TICK_DIV(4), .LIMIT(9), .QSHOW(2)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .ENTER(ENTER), .SW(SW),
    .STATE(STATE), .QUE_T(QUE_T), .QUE_O(QUE_O), .DIN(DIN), .SCORE(SCORE),
    .TIME_LEFT(TIME_LEFT), .LED_OK(LED_OK), .LED_NG(LED_NG)
  );

  fact_game_ctrl #(.NQ(1), .TICK_DIV(4), .LIMIT(9), .QSHOW(2), .Q_OVR(99)) dut_b (
    .CLK(CLK), .nRST(nRST), .START(b_start), .ENTER(b_enter), .SW(b_sw),
    .STATE(b_state), .QUE_T(b_que_t), .QUE_O(b_que_o), .DIN(b_din), .SCORE(b_score),
    .TIME_LEFT(b_time), .LED_OK(b_ok), .LED_NG(b_ng)
  );

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_st(input logic [3:0] s, input int budget, input string tag);
    int n = 0;
    while (STATE !== s && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(STATE), 32'(s));
  endtask

  task automatic pulse_start();
    START = 1'b1; cyc(); START = 1'b0;
  endtask

  // Counts negedges spent in JUDGE, starting on the first JUDGE cycle
  task automatic judge_len(output int n);
    n = 0;
    while (STATE === JUDGE && n < 100) begin
      n++;
      cyc();
    end
  endtask

  task automatic play(input logic [3:0] sw, input bit exp_ok, input int exp_len, input string tag);
    int n;
    wait_st(INPUT, 40, {tag, "_input"});
    SW = sw; ENTER = 1'b1; cyc(); ENTER = 1'b0;
    chk({tag, "_din"}, 32'(DIN), 32'(sw));
    judge_len(n);
    chk({tag, "_judge_len"}, 32'(n), 32'(exp_len));
    chk({tag, "_result"}, 32'(STATE), 32'(RESULT));
    chk({tag, "_led_ok"}, 32'(LED_OK), 32'(exp_ok));
    chk({tag, "_led_ng"}, 32'(LED_NG), 32'(!exp_ok));
  endtask

  logic [3:0] ans  [8] = '{4'd3, 4'd5, 4'd7, 4'd5, 4'd7, 4'd9, 4'd7, 4'd7};
  int         jlen [8] = '{5, 4, 4, 8, 8, 4, 12, 14};
  logic [3:0] qt   [8] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd2, 4'd7, 4'd9};
  logic [3:0] qo   [8] = '{4'd2, 4'd5, 4'd1, 4'd5, 4'd9, 4'd7, 4'd7, 4'd1};

  initial begin
    int n, dec, budget;
    logic [3:0] prev;

    // Reset values
    repeat (3) cyc();
    chk("rst_state", 32'(STATE), 32'(IDLE));
    chk("rst_que_t", 32'(QUE_T), 0);
    chk("rst_que_o", 32'(QUE_O), 0);
    chk("rst_din", 32'(DIN), 0);
    chk("rst_score", 32'(SCORE), 0);
    chk("rst_time", 32'(TIME_LEFT), 9);
    chk("rst_leds", 32'({LED_OK, LED_NG}), 0);
    nRST = 1'b1;
    cyc();

    // ENTER in IDLE is ignored
    ENTER = 1'b1; cyc(); ENTER = 1'b0;
    chk("idle_enter", 32'(STATE), 32'(IDLE));

    // Game 1, round 1: Q=12, correct answer 3
    pulse_start();
    chk("g1_question", 32'(STATE), 32'(QUESTION));
    chk("g1_q0_t", 32'(QUE_T), 1);
    chk("g1_q0_o", 32'(QUE_O), 2);
    wait_st(INPUT, 20, "g1_r1_input");
    chk("g1_r1_time", 32'(TIME_LEFT), 9);
    pulse_start();
    chk("input_start_ignored", 32'(STATE), 32'(INPUT));
    chk("input_start_q", 32'(QUE_O), 2);
    play(4'd3, 1'b1, 5, "g1_r1");
    chk("g1_r1_score", 32'(SCORE), 1);

    // Round 2: Q=15, 4 does not divide
    wait_st(QUESTION, 20, "g1_r2_question");
    chk("g1_r2_t", 32'(QUE_T), 1);
    chk("g1_r2_o", 32'(QUE_O), 5);
    chk("g1_r2_leds_off", 32'({LED_OK, LED_NG}), 0);
    play(4'd4, 1'b0, 4, "g1_r2");
    chk("g1_r2_score", 32'(SCORE), 1);

    // Round 3: Q=21, digit 1 is invalid; round 4: Q=35, 12 is invalid
    play(4'd1, 1'b0, 1, "g1_r3");
    play(4'd12, 1'b0, 1, "g1_r4");
    chk("g1_r4_score", 32'(SCORE), 1);

    // Round 5: Q=49, timeout with TIME_LEFT counting 9..0
    wait_st(INPUT, 40, "g1_r5_input");
    chk("g1_r5_t", 32'(QUE_T), 4);
    prev = TIME_LEFT; dec = 0; budget = 0;
    while (STATE === INPUT && budget < 60) begin
      cyc(); budget++;
      if (TIME_LEFT !== prev) begin
        if (TIME_LEFT === prev - 4'd1) dec++;
        prev = TIME_LEFT;
      end
    end
    chk("timeout_decrements", 32'(dec), 9);
    chk("timeout_result", 32'(STATE), 32'(RESULT));
    chk("timeout_time0", 32'(TIME_LEFT), 0);
    chk("timeout_ng", 32'(LED_NG), 1);
    chk("timeout_ok", 32'(LED_OK), 0);
    wait_st(QUESTION, 20, "timeout_next_q");
    chk("timeout_next_t", 32'(QUE_T), 2);
    chk("timeout_next_o", 32'(QUE_O), 7);

    // Round 6: Q=27, correct ENTER on the expiring tick
    wait_st(INPUT, 40, "g1_r6_input");
    budget = 0;
    while (TIME_LEFT !== 4'd1 && budget < 60) begin
      cyc(); budget++;
    end
    chk("g1_r6_time1", 32'(TIME_LEFT), 1);
    repeat (3) cyc();
    SW = 4'd3; ENTER = 1'b1; cyc(); ENTER = 1'b0;
    chk("late_enter_judge", 32'(STATE), 32'(JUDGE));
    chk("late_enter_time0", 32'(TIME_LEFT), 0);
    judge_len(n);
    chk("late_enter_len", 32'(n), 10);
    chk("late_enter_ok", 32'(LED_OK), 1);
    chk("late_enter_score", 32'(SCORE), 2);

    // Rounds 7-8, then FINISH
    play(4'd7, 1'b1, 12, "g1_r7");
    play(4'd7, 1'b1, 14, "g1_r8");
    wait_st(FINISH, 20, "g1_finish");
    chk("g1_final_score", 32'(SCORE), 4);
    chk("g1_finish_leds", 32'({LED_OK, LED_NG}), 0);
    repeat (10) cyc();
    chk("g1_finish_hold", 32'(STATE), 32'(FINISH));
    ENTER = 1'b1; cyc(); ENTER = 1'b0;
    chk("finish_enter", 32'(STATE), 32'(FINISH));

    // Game 2: restart from FINISH, all correct
    pulse_start();
    chk("g2_question", 32'(STATE), 32'(QUESTION));
    chk("g2_score0", 32'(SCORE), 0);
    for (int i = 0; i < 8; i++) begin
      wait_st(QUESTION, 20, $sformatf("g2_r%0d_q", i));
      chk($sformatf("g2_r%0d_t", i), 32'(QUE_T), 32'(qt[i]));
      chk($sformatf("g2_r%0d_o", i), 32'(QUE_O), 32'(qo[i]));
      play(ans[i], 1'b1, jlen[i], $sformatf("g2_r%0d", i));
      chk($sformatf("g2_r%0d_score", i), 32'(SCORE), 32'(i + 1));
    end
    wait_st(FINISH, 20, "g2_finish");
    chk("g2_final_score", 32'(SCORE), 8);

    // Game 3: reset while the judge is iterating
    pulse_start();
    chk("g3_q_o", 32'(QUE_O), 2);
    play(4'd3, 1'b1, 5, "g3_r1");
    chk("g3_score1", 32'(SCORE), 1);
    wait_st(INPUT, 40, "g3_r2_input");
    SW = 4'd3; ENTER = 1'b1; cyc(); ENTER = 1'b0;
    cyc();
    chk("g3_mid_judge", 32'(STATE), 32'(JUDGE));
    nRST = 1'b0;
    #1;
    chk("async_rst_state", 32'(STATE), 32'(IDLE));
    chk("async_rst_score", 32'(SCORE), 0);
    chk("async_rst_time", 32'(TIME_LEFT), 9);
    chk("async_rst_din", 32'(DIN), 0);
    @(negedge CLK);
    nRST = 1'b1;
    cyc();
    ENTER = 1'b1; cyc(); ENTER = 1'b0;
    cyc();
    chk("post_rst_enter", 32'(STATE), 32'(IDLE));

    // Worst-case judge on the overridden ROM: Q=99, DIN=2
    b_start = 1'b1; cyc(); b_start = 1'b0;
    chk("wc_question", 32'(b_state), 32'(QUESTION));
    chk("wc_t", 32'(b_que_t), 9);
    chk("wc_o", 32'(b_que_o), 9);
    budget = 0;
    while (b_state !== INPUT && budget < 20) begin
      cyc(); budget++;
    end
    chk("wc_input", 32'(b_state), 32'(INPUT));
    b_sw = 4'd2; b_enter = 1'b1; cyc(); b_enter = 1'b0;
    n = 0;
    while (b_state === JUDGE && n < 100) begin
      n++; cyc();
    end
    chk("wc_judge_len", 32'(n), 50);
    chk("wc_ng", 32'(b_ng), 1);
    chk("wc_ok", 32'(b_ok), 0);
    budget = 0;
    while (b_state !== FINISH && budget < 20) begin
      cyc(); budget++;
    end
    chk("wc_finish", 32'(b_state), 32'(FINISH));
    chk("wc_score", 32'(b_score), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fact_game_ctrl.md
# fact_game_ctrl

Sequencing controller for the factorization quiz. Walks each round through question display, timed player input, multi-cycle divisibility judgement and result display, then advances the question index and keeps score. Drives the 4-bit display state code and the digit values consumed by the 7-segment decoder stage. Also drives the OK/NG indicator LEDs.

## Interface
- NQ, 8: questions per game (1..15)
- TICK_DIV, 50_000_000: CLK cycles per 1 s tick
- LIMIT, 9: seconds allowed in INPUT (1..9)
- QSHOW, 2: ticks QUESTION is shown before INPUT
- CLK  in  1  system clock
- nRST  in  1  reset; asynchronous, active-low
- START  in  1  one-cycle pulse (debounced key); starts/restarts a game
- ENTER  in  1  one-cycle pulse; submits SW
- SW  in  4  player's candidate factor, 0..9 valid
- STATE  out  4  display state code (package constants)
- QUE_T  out  4  question tens digit
- QUE_O  out  4  question ones digit
- DIN  out  4  latched player digit
- SCORE  out  4  correct answers this game
- TIME_LEFT  out  4  seconds remaining in INPUT
- LED_OK  out  1  high in RESULT when correct
- LED_NG  out  1  high in RESULT when wrong or timed out

## Operation
- States: IDLE=0, QUESTION=1, INPUT=2, JUDGE=3, RESULT=4, FINISH=5.
- Reset values: STATE=IDLE. QUE_T, QUE_O, DIN, SCORE and LEDs are 0. TIME_LEFT=LIMIT. Question index=0, tick divider=0.
- IDLE, START: index←0, SCORE←0, load question 0 → QUESTION.
- QUESTION: hold for QSHOW ticks → INPUT with TIME_LEFT←LIMIT.
- INPUT:
  - Each tick decrements TIME_LEFT.
  - On ENTER, DIN←SW → JUDGE.
  - When TIME_LEFT reaches 0 with no ENTER: verdict NG → RESULT.
  - ENTER on the same cycle as the expiring tick counts as an answer.
- JUDGE:
  - Invalid digit (DIN<2, DIN>9, or DIN≥Q): NG in 1 cycle.
  - Otherwise rem←Q. Each cycle, rem←rem−DIN while rem≥DIN.
  - Stop when rem<DIN. Correct iff rem==0.
  - Correct: SCORE+1, saturating at 15. → RESULT.
- RESULT:
  - LED_OK or LED_NG is high for 1 full tick.
  - Then, if index==NQ−1 → FINISH; else index+1, load next question → QUESTION.
- FINISH: hold SCORE, LEDs low. START restarts as from IDLE.
- START in QUESTION/INPUT/JUDGE/RESULT: ignored.
- ENTER outside INPUT: ignored.
- Question value Q is 7 bits, 10..99. QUE_T=Q/10 and QUE_O=Q%10, taken from a ROM digit pair so no divider is needed.
- Remainder register: 7 bits unsigned. Subtraction never underflows because of the rem≥DIN guard.
- The tick divider free-runs in every state. A restart does not realign it, so the first tick of a phase may be short by up to TICK_DIV−1 cycles.

## Timing
- All outputs are registered and change only on rising CLK.
- START/ENTER are sampled the cycle they are high; the state change is visible on the next cycle.
- QUESTION lasts QSHOW ticks and RESULT lasts 1 tick, each ±1 tick phase as above.
- JUDGE latency: 1 cycle when invalid, else floor(Q/DIN)+1 cycles. Worst case 50 cycles (Q=99, DIN=2).
- nRST low at any time returns every register to its reset value immediately. Release resumes in IDLE.

## Structure
- Package fact_pkg holds:
  - state localparams IDLE..FINISH (shared with the decoder);
  - question-ROM width constants.
- Sub-module fact_qrom: combinational. Input index[3:0]; outputs Q[6:0], tens[3:0], ones[3:0].
  - Contents: 12, 15, 21, 35, 49, 27, 77, 91.
  - Indices ≥8 wrap (index mod 8).
- Tick divider, FSM and judge subtractor live in fact_game_ctrl.

## Test plan
- Reset mid-JUDGE (TICK_DIV=4): assert nRST while rem is iterating → STATE=0, SCORE=0, TIME_LEFT=LIMIT on the same cycle. ENTER after release is ignored.
- Correct answer: START, wait through QUESTION (Q=12, QUE_T=1, QUE_O=2), ENTER with SW=3 → JUDGE takes 5 cycles, LED_OK for 1 tick, SCORE=1, next Q=15.
- Wrong/invalid answer: Q=15, SW=4 → LED_NG, SCORE unchanged. Q=21, SW=1 → LED_NG after 1-cycle JUDGE. SW=12 → NG.
- Timeout: no ENTER in INPUT → TIME_LEFT counts 9..0, LED_NG, next question. ENTER on the expiring tick with a correct SW → OK.
- Full game: NQ=8, all correct → FINISH with SCORE=8. START then restarts with SCORE=0 and Q=12. START pulses during INPUT do not restart.
- Worst-case judge: force Q=99 via a ROM override, SW=2 → 50-cycle JUDGE, NG.
